// File: rtl/adbg_ahb3_slave_ram.sv
// AHB3-Lite responder backed by a word-addressed RAM, with fixed wait states and two-cycle ERROR responses.
// Address and data phases are pipelined. A write retires at the edge that ends its data phase.
module adbg_ahb3_slave_ram #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  pend, pend_nxt;
  logic [IDXW-1:0]       a_idx;
  logic                  a_write;
  logic [2:0]            a_size;
  logic [OFFW-1:0]       a_off;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept, addr_err, accept_ok, accept_err;
  logic [7:0]            align_mask;
  logic [BYTES-1:0]      wr_mask;
  logic [DATA_WIDTH-1:0] wr_bits, wr_merged, rd_word;
  logic [IDXW-1:0]       rd_idx;
  logic                  wr_fire, rd_load;
  logic                  unused_in;

  assign unused_in  = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign accept     = HSEL & HREADY & HTRANS[1];
  assign align_mask = (8'd1 << HSIZE) - 8'd1;
  assign addr_err   = (HADDR[ADDR_WIDTH-1:OFFW] >= (ADDR_WIDTH-OFFW)'(DEPTH))
                    | (|(HADDR[7:0] & align_mask))
                    | (HSIZE > 3'(OFFW));
  assign accept_ok  = accept & ~addr_err;
  assign accept_err = accept & addr_err;

  assign HREADYOUT  = (state == S_IDLE) || (state == S_ERR2);
  assign HRESP      = (state == S_ERR1) || (state == S_ERR2);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        pend_nxt  = 1'b0;
        if (accept_err) begin
          state_nxt = S_ERR1;
        end else if (accept_ok) begin
          pend_nxt = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Little-endian lane enables from the latched size and byte offset
  always_comb begin
    wr_mask = '0;
    wr_bits = '0;
    for (int b = 0; b < BYTES; b++) begin
      if ((b >= int'(a_off)) && (b < int'(a_off) + (1 << a_size))) wr_mask[b] = 1'b1;
      wr_bits[8*b +: 8] = {8{wr_mask[b]}};
    end
  end

  assign wr_fire   = pend & a_write & (state == S_IDLE);
  assign wr_merged = (mem[a_idx] & ~wr_bits) | (HWDATA & wr_bits);

  // Read data is registered into the final data-phase cycle; a write retiring on the
  // same edge to the same word is forwarded so back-to-back reads never see stale data.
  assign rd_idx  = (state == S_WAIT) ? a_idx : HADDR[OFFW +: IDXW];
  assign rd_load = (accept_ok & ~HWRITE & (WAIT_STATES == 0))
                 | ((state == S_WAIT) & (cnt == 4'd0) & ~a_write);
  assign rd_word = (wr_fire && (a_idx == rd_idx)) ? wr_merged : mem[rd_idx];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      pend    <= 1'b0;
      a_idx   <= '0;
      a_write <= 1'b0;
      a_size  <= 3'd0;
      a_off   <= '0;
      HRDATA  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      if (accept) begin
        a_idx   <= HADDR[OFFW +: IDXW];
        a_write <= HWRITE;
        a_size  <= HSIZE;
        a_off   <= HADDR[OFFW-1:0];
      end
      if (rd_load) HRDATA <= rd_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_fire) mem[a_idx] <= wr_merged;
  end
endmodule
